pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Fetch-stage PC controller for the Y86-64 pipeline. Owns the predicted-PC register and picks each
//   cycle's fetch PC from: prediction, jXX mispredict recovery (M stage) or ret target (W stage).
//   Tracks in-flight ret/halt with a small FSM; drives fetch stall/bubble to the F/D pipeline registers.
// PARAMETERS
//   RESET_PC   64'h0  fetch address loaded into pred_pc on reset
//   W          64     address width (all PC/valC/valP/valM buses)
// PORTS
//   clk            in   1  system clock, all state on rising edge
//   rst            in   1  asynchronous, active-high reset
//   f_valid        in   1  fetched instruction valid (instr memory ready)
//   f_icode        in   4  icode of instruction at fetch_pc
//   f_valC         in   W  constant/target of fetched instruction
//   f_valP         in   W  fall-through address of fetched instruction
//   load_use_stall in   1  hazard unit: hold F (and D) this cycle
//   m_valid        in   1  M stage holds a real (non-bubble) instruction
//   m_icode        in   4  M-stage icode
//   m_cnd          in   1  M-stage branch condition
//   m_valA         in   W  M-stage valA (= valP of a jXX)
//   w_valid        in   1  W stage holds a real instruction
//   w_icode        in   4  W-stage icode
//   w_valM         in   W  W-stage memory read value (ret target)
//   fetch_pc       out  W  address to instruction memory this cycle
//   f_stall        out  1  hold F register / do not advance
//   f_bubble       out  1  inject nop into D next cycle
//   halted         out  1  sequencer parked on halt
// BEHAVIOUR
//   icodes: HALT=4'h0, JXX=4'h7, CALL=4'h8, RET=4'h9.
//   Reset (async): pred_pc=RESET_PC, state=RUN; fetch_pc=RESET_PC, f_stall=0, f_bubble=0, halted=0.
//   fetch_pc is combinational, priority: (1) mispredict = m_valid&m_icode==JXX&!m_cnd -> m_valA;
//     (2) ret_done = w_valid&w_icode==RET -> w_valM; (3) else pred_pc.
//   Prediction (registered, 1-cycle latency): on posedge if advancing, pred_pc <= (f_icode==CALL|JXX)
//     ? f_valC : f_valP. Redirect cycles (1)/(2) fetch from redirect PC and predict from it likewise.
//   FSM states RUN, RET_WAIT, HALTED:
//     RUN:      f_valid&f_icode==RET -> RET_WAIT; f_valid&f_icode==HALT -> HALTED; else stay.
//     RET_WAIT: f_stall=1, f_bubble=1, pred_pc held; ret_done -> RUN (fetch w_valM that cycle,
//               f_stall=0, f_bubble=0).
//     HALTED:   f_stall=1, f_bubble=1, halted=1; only exit is mispredict -> RUN.
//   Mispredict in any state wins: state<=RUN, fetches m_valA, f_bubble=1 (squash D), f_stall=0;
//     aborts a pending RET_WAIT/HALTED fetched on the wrong path.
//   mispredict and ret_done same cycle: mispredict wins (ret cannot be in W behind a wrong-path M).
//   load_use_stall (RUN only, no redirect): f_stall=1, pred_pc and state held, fetch_pc unchanged.
//   f_valid=0 in RUN: f_stall=1, f_bubble=1, no state/pred_pc update.
//   Addresses wrap modulo 2^W; no range checks.
// CONFIGURATION
//   PC_SEQ_PERF_EN defined: three 32-bit saturating counters + outputs perf_mispredict,
//     perf_ret_bubbles, perf_stall_cycles (mispredict events, RET_WAIT cycles, load_use_stall
//     cycles); reset to 0 by rst; saturate at 32'hFFFF_FFFF.
//   Undefined: counters and ports absent; remaining behaviour identical.
// TESTING
//   rst high then low, RESET_PC=64'h100 -> fetch_pc=0x100, all flags 0 during and after reset.
//   Fetch JXX valC=0x200 valP=0x10A -> next fetch_pc=0x200; two cycles later m JXX cnd=0
//     m_valA=0x10A -> fetch_pc=0x10A same cycle, f_bubble=1.
//   Fetch RET at 0x300 -> f_stall=f_bubble=1 for 3 cycles; w RET valM=0x150 -> fetch_pc=0x150,
//     state RUN, next fetch_pc follows prediction.
//   RET fetched on wrong path, mispredict arrives during RET_WAIT -> RUN, fetch_pc=m_valA, no wait.
//   HALT fetched -> halted=1, fetch_pc frozen; later mispredict m_valA=0x40 -> halted=0, fetch 0x40.
//   load_use_stall=1 for 2 cycles at 0x120 -> fetch_pc stays 0x120, pred_pc unchanged;
//     with PC_SEQ_PERF_EN perf_stall_cycles=2.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage PC controller for a Y86-64 pipeline. Holds the predicted PC
//   and selects each cycle's fetch address. The candidates, in priority order,
//   are: jXX mispredict recovery from M, ret target from W, and the predicted PC.
//   A small FSM tracks an in-flight ret (wait for W) and halt (park until a
//   mispredict squashes the halt). It drives stall/bubble to the F/D registers.
//
// Optional feature macro: PC_SEQ_PERF_EN
//   When defined, three 32-bit saturating event counters are added.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   f_valid/f_icode/f_valC/f_valP fetched instruction info
//   load_use_stall               hazard unit hold request
//   m_valid/m_icode/m_cnd/m_valA M-stage jXX resolution
//   w_valid/w_icode/w_valM       W-stage ret target
//   fetch_pc                     instruction memory address (combinational)
//   f_stall, f_bubble            F hold / D nop injection (combinational)
//   halted                       sequencer parked on halt (from state register)
//   perf_*                       event counters (PC_SEQ_PERF_EN only)
module pc_sequencer #(
    parameter int             W        = 64,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    input  logic [3:0]    f_icode,
    input  logic [W-1:0]  f_valC,
    input  logic [W-1:0]  f_valP,
    input  logic          load_use_stall,
    input  logic          m_valid,
    input  logic [3:0]    m_icode,
    input  logic          m_cnd,
    input  logic [W-1:0]  m_valA,
    input  logic          w_valid,
    input  logic [3:0]    w_icode,
    input  logic [W-1:0]  w_valM,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]   perf_mispredict,
    output logic [31:0]   perf_ret_bubbles,
    output logic [31:0]   perf_stall_cycles,
`endif
    output logic [W-1:0]  fetch_pc,
    output logic          f_stall,
    output logic          f_bubble,
    output logic          halted
);

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pred_pc_q, pred_pc_d;

    logic           mispredict;
    logic           ret_done;
    logic [W-1:0]   next_pred;
    state_t         fetch_state;

    assign mispredict = m_valid && (m_icode == IC_JXX) && !m_cnd;
    assign ret_done   = w_valid && (w_icode == IC_RET);

    assign fetch_pc = mispredict ? m_valA :
                      ret_done   ? w_valM : pred_pc_q;

    // Calls and jumps are predicted taken; everything else falls through.
    assign next_pred = ((f_icode == IC_CALL) || (f_icode == IC_JXX)) ? f_valC : f_valP;

    assign fetch_state = (f_icode == IC_RET)  ? ST_RET_WAIT :
                         (f_icode == IC_HALT) ? ST_HALTED   : ST_RUN;

    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        f_stall   = 1'b0;
        f_bubble  = 1'b0;
        if (mispredict) begin
            // Squash the wrong-path instruction in D. This also aborts any
            // ret/halt wait that was entered on the wrong path. If imem is not
            // ready, park on the recovery address so it is re-fetched.
            f_bubble  = 1'b1;
            state_d   = ST_RUN;
            pred_pc_d = f_valid ? next_pred : m_valA;
        end else if (ret_done && (state_q != ST_HALTED)) begin
            // The ret target is fetched as a normal instruction this cycle.
            if (f_valid) begin
                pred_pc_d = next_pred;
                state_d   = fetch_state;
            end else begin
                f_stall   = 1'b1;
                f_bubble  = 1'b1;
                pred_pc_d = w_valM;
                state_d   = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A load-use hold keeps D, so it must not also get a bubble.
                    if (load_use_stall) begin
                        f_stall = 1'b1;
                    end else if (!f_valid) begin
                        f_stall  = 1'b1;
                        f_bubble = 1'b1;
                    end else begin
                        pred_pc_d = next_pred;
                        state_d   = fetch_state;
                    end
                end
                default: begin
                    f_stall  = 1'b1;
                    f_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pred_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
        end
    end

    assign halted = (state_q == ST_HALTED);

`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_mis_q, perf_mis_d;
    logic [31:0] perf_ret_q, perf_ret_d;
    logic [31:0] perf_stl_q, perf_stl_d;
    logic        inc_mis, inc_ret, inc_stl;

    assign inc_mis = mispredict;
    assign inc_ret = (state_q == ST_RET_WAIT) && !mispredict && !ret_done;
    assign inc_stl = (state_q == ST_RUN) && !mispredict && !ret_done && load_use_stall;

    always_comb begin
        perf_mis_d = perf_mis_q + {31'd0, (inc_mis && (perf_mis_q != 32'hFFFF_FFFF))};
        perf_ret_d = perf_ret_q + {31'd0, (inc_ret && (perf_ret_q != 32'hFFFF_FFFF))};
        perf_stl_d = perf_stl_q + {31'd0, (inc_stl && (perf_stl_q != 32'hFFFF_FFFF))};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mis_q <= '0;
            perf_ret_q <= '0;
            perf_stl_q <= '0;
        end else begin
            perf_mis_q <= perf_mis_d;
            perf_ret_q <= perf_ret_d;
            perf_stl_q <= perf_stl_d;
        end
    end

    assign perf_mispredict   = perf_mis_q;
    assign perf_ret_bubbles  = perf_ret_q;
    assign perf_stall_cycles = perf_stl_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        f_valid;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        load_use_stall;
    logic        m_valid;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valA;
    logic        w_valid;
    logic [3:0]  w_icode;
    logic [63:0] w_valM;
    logic [63:0] fetch_pc;
    logic        f_stall;
    logic        f_bubble;
    logic        halted;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] perf_mispredict;
    logic [31:0] perf_ret_bubbles;
    logic [31:0] perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, JXX = 4'h7, CALL = 4'h8, RET = 4'h9;

    pc_sequencer #(.W(64), .RESET_PC(64'h100)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .load_use_stall(load_use_stall),
        .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
        .w_valid(w_valid), .w_icode(w_icode), .w_valM(w_valM),
`ifdef PC_SEQ_PERF_EN
        .perf_mispredict(perf_mispredict),
        .perf_ret_bubbles(perf_ret_bubbles),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .fetch_pc(fetch_pc), .f_stall(f_stall), .f_bubble(f_bubble), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 1ns after the edge, checks 2ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        f_valid = 1'b1;
        f_icode = ic;
        f_valC  = vc;
        f_valP  = vp;
        #1;
    endtask

    task automatic check_out(input string name, input logic [63:0] pc,
                             input logic st, input logic bb, input logic hl);
        n_checks++;
        if (fetch_pc !== pc) begin
            n_fail++;
            $display("FAIL %s fetch_pc: got %h expected %h", name, fetch_pc, pc);
        end
        n_checks++;
        if (f_stall !== st) begin
            n_fail++;
            $display("FAIL %s f_stall: got %b expected %b", name, f_stall, st);
        end
        n_checks++;
        if (f_bubble !== bb) begin
            n_fail++;
            $display("FAIL %s f_bubble: got %b expected %b", name, f_bubble, bb);
        end
        n_checks++;
        if (halted !== hl) begin
            n_fail++;
            $display("FAIL %s halted: got %b expected %b", name, halted, hl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_use_stall = 1'b0;
        m_valid = 1'b0; m_icode = NOP; m_cnd = 1'b0; m_valA = '0;
        w_valid = 1'b0; w_icode = NOP; w_valM = '0;
        fetch(NOP, 64'h0, 64'h101);
        check_out("reset_active", 64'h100, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_out("reset_held", 64'h100, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_out("reset_release", 64'h100, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_PERF_EN
        n_checks++;
        if (perf_stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d expected 0", perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_jxx_mispredict();
        fetch(JXX, 64'h200, 64'h10A);
        tick();
        check_out("jxx_predict_taken", 64'h200, 1'b0, 1'b0, 1'b0);
        fetch(NOP, 64'h0, 64'h209);
        tick();
        check_out("jxx_follow1", 64'h209, 1'b0, 1'b0, 1'b0);
        fetch(NOP, 64'h0, 64'h20A);
        tick();
        m_valid = 1'b1; m_icode = JXX; m_cnd = 1'b0; m_valA = 64'h10A;
        fetch(NOP, 64'h0, 64'h10B);
        check_out("mispredict_redirect", 64'h10A, 1'b0, 1'b1, 1'b0);
        tick();
        m_valid = 1'b0;
        #1;
        check_out("after_mispredict", 64'h10B, 1'b0, 1'b0, 1'b0);
        m_valid = 1'b1; m_cnd = 1'b1; m_valA = 64'h999;
        #1;
        check_out("taken_no_redirect", 64'h10B, 1'b0, 1'b0, 1'b0);
        m_valid = 1'b0; m_cnd = 1'b0;
        #1;
    endtask

    task automatic test_ret();
        fetch(CALL, 64'h300, 64'h114);
        tick();
        fetch(RET, 64'h0, 64'h301);
        check_out("ret_fetch", 64'h300, 1'b0, 1'b0, 1'b0);
        tick();
        fetch(NOP, 64'h0, 64'h302);
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("ret_wait%0d", i), 64'h301, 1'b1, 1'b1, 1'b0);
            tick();
        end
        w_valid = 1'b1; w_icode = RET; w_valM = 64'h150;
        fetch(NOP, 64'h0, 64'h152);
        check_out("ret_done", 64'h150, 1'b0, 1'b0, 1'b0);
        tick();
        w_valid = 1'b0;
        #1;
        check_out("after_ret", 64'h152, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ret_abort();
        fetch(RET, 64'h0, 64'h153);
        tick();
        fetch(NOP, 64'h0, 64'h154);
        check_out("wrong_path_ret_wait", 64'h153, 1'b1, 1'b1, 1'b0);
        m_valid = 1'b1; m_icode = JXX; m_cnd = 1'b0; m_valA = 64'h500;
        fetch(NOP, 64'h0, 64'h502);
        check_out("ret_abort_redirect", 64'h500, 1'b0, 1'b1, 1'b0);
        tick();
        m_valid = 1'b0;
        #1;
        check_out("ret_abort_run", 64'h502, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        fetch(HALT, 64'h0, 64'h503);
        check_out("halt_fetch", 64'h502, 1'b0, 1'b0, 1'b0);
        tick();
        fetch(JXX, 64'hABC, 64'h504);
        check_out("halted1", 64'h503, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check_out("halted_frozen", 64'h503, 1'b1, 1'b1, 1'b1);
        m_valid = 1'b1; m_icode = JXX; m_cnd = 1'b0; m_valA = 64'h40;
        fetch(NOP, 64'h0, 64'h41);
        check_out("halt_mispredict", 64'h40, 1'b0, 1'b1, 1'b1);
        tick();
        m_valid = 1'b0;
        #1;
        check_out("halt_exit", 64'h41, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_use();
        fetch(CALL, 64'h120, 64'h4A);
        tick();
        load_use_stall = 1'b1;
        fetch(JXX, 64'h777, 64'h121);
        check_out("lus_cycle1", 64'h120, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("lus_cycle2", 64'h120, 1'b1, 1'b0, 1'b0);
        tick();
        load_use_stall = 1'b0;
        fetch(NOP, 64'h0, 64'h121);
        check_out("lus_release", 64'h120, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_PERF_EN
        n_checks++;
        if (perf_stall_cycles !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_stall_cycles: got %0d expected 2", perf_stall_cycles);
        end
`endif
        tick();
        check_out("lus_advance", 64'h121, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fvalid_low();
        fetch(JXX, 64'h888, 64'h123);
        f_valid = 1'b0;
        #1;
        check_out("fvalid_low", 64'h121, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("fvalid_low_hold", 64'h121, 1'b1, 1'b1, 1'b0);
        fetch(NOP, 64'h0, 64'h122);
        check_out("fvalid_back", 64'h121, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_priority();
        m_valid = 1'b1; m_icode = JXX; m_cnd = 1'b0; m_valA = 64'h600;
        w_valid = 1'b1; w_icode = RET; w_valM = 64'h700;
        fetch(NOP, 64'h0, 64'h601);
        check_out("mispredict_beats_ret", 64'h600, 1'b0, 1'b1, 1'b0);
        tick();
        m_valid = 1'b0; w_valid = 1'b0;
        #1;
        check_out("after_priority", 64'h601, 1'b0, 1'b0, 1'b0);
        fetch(NOP, 64'h0, 64'h0);
        tick();
        check_out("wrap_zero", 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_jxx_mispredict();
        test_ret();
        test_ret_abort();
        test_halt();
        test_load_use();
        test_fvalid_low();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
